// File: rtl/rggen_rtl_pkg.sv
// rggen_rtl_pkg: shared status/arbiter-state types and a width helper for the register access arbiter
package rggen_rtl_pkg;
  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'd0,
    RGGEN_EXOKAY       = 2'd1,
    RGGEN_SLAVE_ERROR  = 2'd2,
    RGGEN_DECODE_ERROR = 2'd3
  } rggen_status;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    RESPONSE = 2'd2
  } rggen_arbiter_state;
  function automatic int rggen_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rggen_round_robin_selector.sv
// rggen_round_robin_selector: combinational first-set search of i_request from i_ptr (wrapping), giving one-hot o_grant and o_index
module rggen_round_robin_selector #(
  parameter int HOSTS       = 2,
  parameter int INDEX_WIDTH = 1
)(
  input  logic [HOSTS-1:0]       i_request,
  input  logic [INDEX_WIDTH-1:0] i_ptr,
  output logic [HOSTS-1:0]       o_grant,
  output logic [INDEX_WIDTH-1:0] o_index
);
  always_comb begin
    o_grant = '0;
    o_index = '0;
    for (int i = HOSTS - 1; i >= 0; i--) begin
      for (int j = 0; j < HOSTS; j++) begin
        if (j == (int'(i_ptr) + i) % HOSTS && i_request[j]) begin
          o_grant    = '0;
          o_grant[j] = 1'b1;
          o_index    = INDEX_WIDTH'(j);
        end
      end
    end
  end
endmodule

// File: rtl/rggen_register_access_arbiter.sv
// rggen_register_access_arbiter: round-robin share of one register access port among HOSTS requesters (i_host_* in, o_host_ready/data/status out; o_reg_* out, i_reg_* in) with optional timeout
module rggen_register_access_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int HOSTS          = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
)(
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [HOSTS-1:0]                  i_host_valid,
  input  logic [HOSTS-1:0]                  i_host_write,
  input  logic [HOSTS*ADDRESS_WIDTH-1:0]    i_host_address,
  input  logic [HOSTS*DATA_WIDTH-1:0]       i_host_write_data,
  input  logic [HOSTS*(DATA_WIDTH/8)-1:0]   i_host_strobe,
  output logic [HOSTS-1:0]                  o_host_ready,
  output logic [DATA_WIDTH-1:0]             o_host_read_data,
  output logic [1:0]                        o_host_status,
  output logic                              o_reg_valid,
  output logic                              o_reg_write,
  output logic [ADDRESS_WIDTH-1:0]          o_reg_address,
  output logic [DATA_WIDTH-1:0]             o_reg_write_data,
  output logic [DATA_WIDTH/8-1:0]           o_reg_strobe,
  input  logic                              i_reg_ready,
  input  logic [1:0]                        i_reg_status,
  input  logic [DATA_WIDTH-1:0]             i_reg_read_data
);
  localparam int IW = rggen_clog2_min1(HOSTS);
  localparam int SW = DATA_WIDTH / 8;
  rggen_arbiter_state state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] grant;
  logic [IW-1:0] sel_index;
  logic [HOSTS-1:0] sel_grant;
  logic sel_write;
  logic [ADDRESS_WIDTH-1:0] sel_address;
  logic [DATA_WIDTH-1:0] sel_write_data;
  logic [SW-1:0] sel_strobe;
  logic timeout;
  logic done;
  rggen_round_robin_selector #(.HOSTS(HOSTS), .INDEX_WIDTH(IW)) u_selector (
    .i_request (i_host_valid),
    .i_ptr     (ptr),
    .o_grant   (sel_grant),
    .o_index   (sel_index)
  );
  always_comb begin
    sel_write      = 1'b0;
    sel_address    = '0;
    sel_write_data = '0;
    sel_strobe     = '0;
    for (int h = 0; h < HOSTS; h++) begin
      if (sel_grant[h]) begin
        sel_write      = i_host_write[h];
        sel_address    = i_host_address[h*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_write_data = i_host_write_data[h*DATA_WIDTH +: DATA_WIDTH];
        sel_strobe     = i_host_strobe[h*SW +: SW];
      end
    end
  end
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] cnt;
      always_ff @(posedge i_clk) begin
        if (i_rst || state != ACCESS) cnt <= '0;
        else if (!i_reg_ready) cnt <= cnt + CW'(1);
      end
      assign timeout = state == ACCESS && !i_reg_ready && cnt == CW'(TIMEOUT_CYCLES - 1);
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate
  assign done = state == ACCESS && ((o_reg_valid && i_reg_ready) || timeout);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      ptr              <= '0;
      grant            <= '0;
      o_host_ready     <= '0;
      o_host_read_data <= '0;
      o_host_status    <= RGGEN_OKAY;
      o_reg_valid      <= 1'b0;
      o_reg_write      <= 1'b0;
      o_reg_address    <= '0;
      o_reg_write_data <= '0;
      o_reg_strobe     <= '0;
    end else if (state == IDLE) begin
      if (|i_host_valid) begin
        state            <= ACCESS;
        grant            <= sel_index;
        o_reg_valid      <= 1'b1;
        o_reg_write      <= sel_write;
        o_reg_address    <= sel_address;
        o_reg_write_data <= sel_write_data;
        o_reg_strobe     <= sel_strobe;
      end
    end else if (state == ACCESS) begin
      if (done) begin
        state            <= RESPONSE;
        o_reg_valid      <= 1'b0;
        o_host_ready     <= HOSTS'(1) << grant;
        o_host_read_data <= (i_reg_ready && !o_reg_write) ? i_reg_read_data : '0;
        o_host_status    <= i_reg_ready ? i_reg_status : RGGEN_SLAVE_ERROR;
      end
    end else begin
      state            <= IDLE;
      ptr              <= (grant == IW'(HOSTS - 1)) ? '0 : grant + IW'(1);
      o_host_ready     <= '0;
      o_host_read_data <= '0;
      o_host_status    <= RGGEN_OKAY;
    end
  end
endmodule
